video_timing_gen: RTL and testbench

- Generates raster timing and pixel data for the HDMI transmitter stage that drives the MS7210.
- Produces a pixel-enable, line sync, frame sync and 24-bit RGB stream on the shared pixel clock.
- Also emits the pixel coordinates and a frame-start strobe, so a later frame-buffer reader can replace the built-in test patterns.
- Default timing is 1280x720@60 (74.25 MHz pixel clock).

---
 rtl/video_timing_gen_if.sv | 24 ++
 rtl/video_timing_gen.sv | 120 ++++++++++++
 tb/tb_video_timing_gen.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: run control in, raster timing and RGB pixel stream out
// Ports (master = generator): en, pattern_sel in; running, p_en, h_sync, v_sync, p_r, p_g, p_b, x, y, frame_start out
interface video_timing_gen_if;
    logic        en;
    logic [1:0]  pattern_sel;
    logic        running;
    logic        p_en;
    logic        h_sync;
    logic        v_sync;
    logic [7:0]  p_r;
    logic [7:0]  p_g;
    logic [7:0]  p_b;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;
    modport master (
        input  en, pattern_sel,
        output running, p_en, h_sync, v_sync, p_r, p_g, p_b, x, y, frame_start
    );
    modport slave (
        output en, pattern_sel,
        input  running, p_en, h_sync, v_sync, p_r, p_g, p_b, x, y, frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing and built-in test-pattern generator for the HDMI transmitter
// Ports: clk pixel clock; rst asynchronous active-high reset;
//        vid (master): en/pattern_sel in; running, p_en, h_sync, v_sync, p_r/p_g/p_b, x, y, frame_start out
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1
) (
    input logic                clk,
    input logic                rst,
    video_timing_gen_if.master vid
);
    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] HL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] VA  = 12'(V_ACTIVE);
    localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] VL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    // last column index inside one colour bar
    localparam logic [11:0] BL  = 12'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 - 1 : 0);
    localparam logic        HSP = (HS_POL != 0);
    localparam logic        VSP = (VS_POL != 0);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, bar_cnt_q, bar_cnt_d;
    logic [3:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pat_q, pat_d;
    logic        p_en_q, p_en_d, h_sync_q, h_sync_d, v_sync_q, v_sync_d, fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        run, h_last, v_last, first, active;
    logic [23:0] bar_rgb, pix;

    always_comb begin
        state_d   = state_q;
        run       = state_q == RUN;
        h_last    = h_cnt_q == HL;
        v_last    = v_cnt_q == VL;
        first     = run && h_cnt_q == '0 && v_cnt_q == '0;
        if (!run && vid.en)
            state_d = RUN;
        else if (run && h_last && v_last && !vid.en)
            state_d = IDLE;
        h_cnt_d   = (run && !h_last) ? h_cnt_q + 12'd1 : '0;
        v_cnt_d   = !run ? '0 : !h_last ? v_cnt_q : v_last ? '0 : v_cnt_q + 12'd1;
        // bar position tracked by a per-line column counter; index 8 means past the last bar
        bar_cnt_d = (!run || h_last || bar_cnt_q == BL) ? '0 : bar_cnt_q + 12'd1;
        bar_idx_d = (!run || h_last) ? '0 :
                    (bar_cnt_q == BL && !bar_idx_q[3]) ? bar_idx_q + 4'd1 : bar_idx_q;
        // the frame's first pixel already uses the freshly sampled selection
        pat_d     = first ? vid.pattern_sel : pat_q;
        // white, yellow, cyan, green, magenta, red, blue, black
        bar_rgb   = bar_idx_q[3] ? '0 : {{8{~bar_idx_q[1]}}, {8{~bar_idx_q[2]}}, {8{~bar_idx_q[0]}}};
        pix       = pat_d == 2'd0 ? bar_rgb :
                    pat_d == 2'd1 ? {3{h_cnt_q[7:0]}} :
                    pat_d == 2'd2 ? {24{h_cnt_q[5] ^ v_cnt_q[5]}} : 24'hFFFFFF;
        active    = run && h_cnt_q < HA && v_cnt_q < VA;
        p_en_d    = active;
        rgb_d     = active ? pix : '0;
        h_sync_d  = (run && h_cnt_q >= HS0 && h_cnt_q < HS1) ? HSP : ~HSP;
        v_sync_d  = (run && v_cnt_q >= VS0 && v_cnt_q < VS1) ? VSP : ~VSP;
        x_d       = h_cnt_q;
        y_d       = v_cnt_q;
        fs_d      = first;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            pat_q     <= '0;
            p_en_q    <= 1'b0;
            h_sync_q  <= ~HSP;
            v_sync_q  <= ~VSP;
            rgb_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            pat_q     <= pat_d;
            p_en_q    <= p_en_d;
            h_sync_q  <= h_sync_d;
            v_sync_q  <= v_sync_d;
            rgb_q     <= rgb_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fs_q      <= fs_d;
        end
    end

    assign vid.running     = state_q == RUN;
    assign vid.p_en        = p_en_q;
    assign vid.h_sync      = h_sync_q;
    assign vid.v_sync      = v_sync_q;
    assign vid.p_r         = rgb_q[23:16];
    assign vid.p_g         = rgb_q[15:8];
    assign vid.p_b         = rgb_q[7:0];
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.frame_start = fs_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen over small, negative-polarity, medium and default timings
module tb_video_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if vs ();
    video_timing_gen_if vn ();
    video_timing_gen_if vm ();
    video_timing_gen_if vd ();

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_s (.clk(clk), .rst(rst), .vid(vs));
    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                       .HS_POL(0), .VS_POL(0)) u_n (.clk(clk), .rst(rst), .vid(vn));
    video_timing_gen #(.H_ACTIVE(68), .H_FP(4), .H_SYNC(4), .H_BP(4),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_m (.clk(clk), .rst(rst), .vid(vm));
    video_timing_gen u_d (.clk(clk), .rst(rst), .vid(vd));

    assign vn.en          = vs.en;
    assign vn.pattern_sel = 2'd0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] q_s[$];
    logic [47:0] q_m[$];
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input int pat, input int x, input int y, input int ha);
        logic [7:0] b;
        b = 8'(x);
        case (pat)
            0: return (x / (ha / 8) < 8) ? bars[x / (ha / 8)] : 24'h0;
            1: return {b, b, b};
            2: return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // monitor: every presented pixel is checked against the next expected entry
    always @(negedge clk) begin
        if (!rst && vs.p_en) begin
            if (q_s.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_s unexpected pixel x=%0d y=%0d", vs.x, vs.y);
            end else
                chk("sb_s pixel", {vs.x, vs.y, vs.p_r, vs.p_g, vs.p_b}, q_s.pop_front());
        end
        if (!rst && vm.p_en) begin
            if (q_m.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_m unexpected pixel x=%0d y=%0d", vm.x, vm.y);
            end else
                chk("sb_m pixel", {vm.x, vm.y, vm.p_r, vm.p_g, vm.p_b}, q_m.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, h, v;
        logic on;
        logic [4:0] e;
        vs.en = 0; vs.pattern_sel = 0;
        vm.en = 0; vm.pattern_sel = 0;
        vd.en = 0; vd.pattern_sel = 0;
        repeat (3) @(negedge clk);
        chk("reset s outputs", {vs.running, vs.p_en, vs.h_sync, vs.v_sync, vs.frame_start}, 5'b0);
        chk("reset s data", {vs.p_r, vs.p_g, vs.p_b, vs.x, vs.y}, 48'h0);
        chk("reset n syncs", {vn.h_sync, vn.v_sync}, 2'b11);
        rst = 1'b0;
        @(negedge clk);
        chk("idle without en", {vs.running, vs.p_en}, 2'b00);

        // small timing: three frames, en dropped during line 2 of the third
        for (int f = 0; f < 3; f++)
            for (int yy = 0; yy < 4; yy++)
                for (int xx = 0; xx < 8; xx++)
                    q_s.push_back({12'(xx), 12'(yy), bars[xx]});
        vs.en = 1;
        for (int n = 1; n <= 310; n++) begin
            @(negedge clk);
            c  = n - 2;
            on = c >= 0 && c <= 293;
            h  = on ? c % 14 : 0;
            v  = on ? (c / 14) % 7 : 0;
            e  = {n <= 294, on && h < 8 && v < 4, on && h >= 10 && h < 12, on && v == 5, on && c % 98 == 0};
            chk("small timing", {vs.running, vs.p_en, vs.h_sync, vs.v_sync, vs.frame_start}, e);
            chk("small neg-pol syncs", {vn.h_sync, vn.v_sync}, {~e[2], ~e[1]});
            if (n - 1 == 196 + 31) vs.en = 0;
        end
        chk("sb_s drained", q_s.size(), 0);

        // medium timing: pattern changes mid-frame, taking effect next frame
        for (int f = 0; f < 4; f++)
            for (int yy = 0; yy < 4; yy++)
                for (int xx = 0; xx < 68; xx++)
                    q_m.push_back({12'(xx), 12'(yy), exp_rgb(f, xx, yy, 68)});
        vm.en = 1;
        for (int n = 1; n <= 2250; n++) begin
            @(negedge clk);
            if (n == 39)  chk("m bars x37 y0", {vm.x, vm.p_r, vm.p_g, vm.p_b}, {12'd37, 24'hFF00FF});
            if (n == 67)  chk("m remainder black", {vm.p_en, vm.x, vm.p_r, vm.p_g, vm.p_b}, {1'b1, 12'd65, 24'h0});
            if (n == 199) chk("m still bars after change", {vm.x, vm.y, vm.p_r, vm.p_g, vm.p_b}, {12'd37, 12'd2, 24'hFF00FF});
            if (n == 599) chk("m ramp x37", {vm.x, vm.p_r, vm.p_g, vm.p_b}, {12'd37, 24'h252525});
            for (int f = 0; f < 3; f++)
                if (n - 1 == f * 560 + 100) vm.pattern_sel = 2'(f + 1);
            if (n - 1 == 3 * 560 + 100) vm.en = 0;
        end
        chk("m stopped", {vm.running, vm.p_en}, 2'b00);
        chk("sb_m drained", q_m.size(), 0);

        // default 720p timing: first line of colour bars
        vd.en = 1;
        for (int n = 1; n <= 1435; n++) begin
            @(negedge clk);
            if (n == 2)    chk("d first pixel", {vd.frame_start, vd.x, vd.y, vd.p_r, vd.p_g, vd.p_b}, {1'b1, 24'd0, 24'hFFFFFF});
            if (n == 3)    chk("d frame_start one cycle", vd.frame_start, 1'b0);
            if (n == 162)  chk("d x160", {vd.x, vd.p_r, vd.p_g, vd.p_b}, {12'd160, 24'hFFFF00});
            if (n == 1281) chk("d x1279", {vd.p_en, vd.x, vd.p_r, vd.p_g, vd.p_b}, {1'b1, 12'd1279, 24'h0});
            if (n == 1282) chk("d blank", {vd.p_en, vd.h_sync, vd.p_r, vd.p_g, vd.p_b}, 26'h0);
            if (n == 1392) chk("d hsync on", vd.h_sync, 1'b1);
            if (n == 1432) chk("d hsync off", vd.h_sync, 1'b0);
        end

        // small timing: restart, then asynchronous reset at h_cnt=5, v_cnt=2
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 8; xx++)
                q_s.push_back({12'(xx), 12'(yy), bars[xx]});
        vs.en = 1;
        @(negedge clk);
        chk("restart cycle 1", {vs.running, vs.p_en, vs.frame_start}, 3'b100);
        @(negedge clk);
        chk("restart cycle 2", {vs.p_en, vs.frame_start, vs.x, vs.y}, {2'b11, 24'd0});
        repeat (32) @(negedge clk);
        chk("pre-reset pixel", {vs.p_en, vs.x, vs.y}, {1'b1, 12'd4, 12'd2});
        #2 rst = 1'b1;
        #1;
        chk("async reset s", {vs.running, vs.p_en, vs.h_sync, vs.frame_start, vs.p_r, vs.p_g, vs.p_b}, 28'h0);
        chk("async reset n syncs", {vn.h_sync, vn.v_sync}, 2'b11);
        q_s.delete();
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 8; xx++)
                q_s.push_back({12'(xx), 12'(yy), bars[xx]});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset cycle 1", {vs.running, vs.p_en}, 2'b10);
        @(negedge clk);
        chk("post-reset first pixel", {vs.p_en, vs.frame_start, vs.x, vs.y}, {2'b11, 24'd0});
        vs.en = 0;
        for (int i = 0; i < 200 && vs.running; i++) @(negedge clk);
        chk("post-reset stop", vs.running, 1'b0);
        repeat (3) @(negedge clk);
        chk("idle after stop", {vs.p_en, vs.h_sync, vs.v_sync, vn.h_sync, vn.v_sync}, 5'b00011);
        chk("sb_s drained after reset", q_s.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
